// File: rtl/stream_stage_sequencer_if.sv
// Handshake, stream-routing and status bundle between the stage sequencer and its surroundings.
// master = sequencer side, slave = kernel/stage/environment side.
interface stream_stage_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             ap_start;
    logic             ap_done;
    logic             ap_ready;
    logic             ap_idle;
    logic             s0_ap_start;
    logic             s0_ap_done;
    logic             s1_ap_start;
    logic             s1_ap_done;
    logic             in_s_TVALID;
    logic             in_s_TREADY;
    logic             s0_in_TVALID;
    logic             s0_in_TREADY;
    logic             s1_in_TVALID;
    logic             s1_in_TREADY;
    logic [CNT_W-1:0] beat0_cnt;
    logic [CNT_W-1:0] beat1_cnt;
    logic             stall_err;
    logic             beat_err;

    modport master (
        input  ap_start, s0_ap_done, s1_ap_done,
        input  in_s_TVALID, s0_in_TREADY, s1_in_TREADY,
        output ap_done, ap_ready, ap_idle, s0_ap_start, s1_ap_start,
        output in_s_TREADY, s0_in_TVALID, s1_in_TVALID,
        output beat0_cnt, beat1_cnt, stall_err, beat_err
    );

    modport slave (
        output ap_start, s0_ap_done, s1_ap_done,
        output in_s_TVALID, s0_in_TREADY, s1_in_TREADY,
        input  ap_done, ap_ready, ap_idle, s0_ap_start, s1_ap_start,
        input  in_s_TREADY, s0_in_TVALID, s1_in_TVALID,
        input  beat0_cnt, beat1_cnt, stall_err, beat_err
    );
endinterface

// File: rtl/stream_stage_sequencer.sv
// Two-stage kernel sequencer IDLE->S0->GAP->S1->FIN sharing in_s; starts/done/idle registered, stage start one cycle after ap_start.
// Backpressure: in_s_TREADY mirrors only the active stage's TREADY (0 otherwise); SEQ_BEAT_CHECK_EN builds the beat-count check.
module stream_stage_sequencer #(
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 1024,
    parameter int EXP_BEATS0  = 256,
    parameter int EXP_BEATS1  = 64
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    stream_stage_sequencer_if.master  io
);

    if (STALL_LIMIT < 1 || EXP_BEATS0 < 0 || EXP_BEATS1 < 0) begin : g_param_chk
        $error("stream_stage_sequencer: STALL_LIMIT must be >= 1 and expected beat counts non-negative");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_S0,
        ST_GAP,
        ST_S1,
        ST_FIN
    } state_t;

    localparam logic [CNT_W-1:0] STALL_LIM_C = CNT_W'(STALL_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX_C   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;
    logic [CNT_W-1:0] wd_q, wd_d;
    logic             stall_q, stall_d;
    logic             s0_start_q, s1_start_q, done_q, idle_q;

    logic             in_s0, in_s1;
    logic             act_rdy, beat_acc, starved;
    logic             start_acc, leave;

    // Stream routing is a pure decode of the state register.
    always_comb begin
        in_s0           = (state_q == ST_S0);
        in_s1           = (state_q == ST_S1);
        io.s0_in_TVALID = in_s0 & io.in_s_TVALID;
        io.s1_in_TVALID = in_s1 & io.in_s_TVALID;
        act_rdy         = (in_s0 & io.s0_in_TREADY) | (in_s1 & io.s1_in_TREADY);
        io.in_s_TREADY  = act_rdy;
        beat_acc        = io.in_s_TVALID & act_rdy;
        starved         = act_rdy & ~io.in_s_TVALID;
    end

    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.ap_start) begin
                    state_d   = ST_S0;
                    start_acc = 1'b1;
                end
            end
            ST_S0:   if (io.s0_ap_done) state_d = ST_GAP;
            ST_GAP:  state_d = ST_S1;
            ST_S1:   if (io.s1_ap_done) state_d = ST_FIN;
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        leave = (state_d != state_q);
    end

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (start_acc) begin
            cnt0_d = '0;
            cnt1_d = '0;
        end else begin
            if (beat_acc && in_s0 && cnt0_q != CNT_MAX_C) cnt0_d = cnt0_q + 1'b1;
            if (beat_acc && in_s1 && cnt1_q != CNT_MAX_C) cnt1_d = cnt1_q + 1'b1;
        end
    end

    // The error flag is judged on the incremented count before any state-change clear,
    // so a limit reached on a stage's last cycle is still reported.
    always_comb begin
        wd_d    = '0;
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = 1'b0;
        end else if (starved) begin
            if (wd_q >= STALL_LIM_C - 1'b1) stall_d = 1'b1;
            wd_d = (wd_q >= STALL_LIM_C) ? wd_q : wd_q + 1'b1;
        end
        if (leave) wd_d = '0;
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            wd_q       <= '0;
            stall_q    <= 1'b0;
            s0_start_q <= 1'b0;
            s1_start_q <= 1'b0;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            wd_q       <= wd_d;
            stall_q    <= stall_d;
            s0_start_q <= (state_d == ST_S0);
            s1_start_q <= (state_d == ST_S1);
            done_q     <= (state_d == ST_FIN);
            idle_q     <= (state_d == ST_IDLE);
        end
    end

`ifdef SEQ_BEAT_CHECK_EN
    localparam logic [CNT_W-1:0] EXP0_C = CNT_W'(EXP_BEATS0);
    localparam logic [CNT_W-1:0] EXP1_C = CNT_W'(EXP_BEATS1);

    logic berr_q, berr_d;

    // cnt*_d already includes a beat accepted in the done cycle.
    always_comb begin
        berr_d = berr_q;
        if (start_acc) begin
            berr_d = 1'b0;
        end else begin
            if (in_s0 && io.s0_ap_done && cnt0_d != EXP0_C) berr_d = 1'b1;
            if (in_s1 && io.s1_ap_done && cnt1_d != EXP1_C) berr_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) berr_q <= 1'b0;
        else        berr_q <= berr_d;
    end

    assign io.beat_err = berr_q;
`else
    assign io.beat_err = 1'b0;
`endif

    assign io.s0_ap_start = s0_start_q;
    assign io.s1_ap_start = s1_start_q;
    assign io.ap_done     = done_q;
    assign io.ap_ready    = done_q;
    assign io.ap_idle     = idle_q;
    assign io.beat0_cnt   = cnt0_q;
    assign io.beat1_cnt   = cnt1_q;
    assign io.stall_err   = stall_q;

endmodule

// File: tb/tb_stream_stage_sequencer.sv
// Randomized bench for stream_stage_sequencer: driver tracks run phase and expected counts, monitor checks every cycle and pops run results on ap_done.
module tb_stream_stage_sequencer;

    localparam int CNT_W = 32;
    localparam int LIMIT = 8;
    localparam int EXP0  = 256;
    localparam int EXP1  = 64;

    localparam int P_IDLE = 0;
    localparam int P_S0   = 1;
    localparam int P_GAP  = 2;
    localparam int P_S1   = 3;
    localparam int P_FIN  = 4;
    localparam int P_OFF  = 5;

    typedef struct {
        int b0;
        int b1;
        bit st;
        bit be;
    } result_t;

    logic ap_clk = 1'b0;
    logic ap_rst;

    stream_stage_sequencer_if #(.CNT_W(CNT_W)) b();

    stream_stage_sequencer #(
        .CNT_W      (CNT_W),
        .STALL_LIMIT(LIMIT),
        .EXP_BEATS0 (EXP0),
        .EXP_BEATS1 (EXP1)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .io    (b)
    );

    always #5 ap_clk = ~ap_clk;

    result_t sb_q[$];
    int      checks = 0;
    int      errors = 0;
    int      phase  = P_OFF;
    int      m_cnt0 = 0;
    int      m_cnt1 = 0;
    int      streak = 0;
    bit      m_stall = 1'b0;
    bit      m_berr  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Monitor: every cycle compares against the bench's own notion of phase and counts.
    always @(negedge ap_clk) begin
        result_t r;
        if (!ap_rst && phase != P_OFF) begin
            chk("beat0_cnt", b.beat0_cnt, m_cnt0);
            chk("beat1_cnt", b.beat1_cnt, m_cnt1);
            chk("stall_err", b.stall_err, m_stall);
            chk("beat_err", b.beat_err, m_berr);
            chk("ap_ready_eq_done", b.ap_ready, b.ap_done);
            case (phase)
                P_S0: begin
                    chk("s0_start_in_s0", b.s0_ap_start, 1);
                    chk("s1_start_in_s0", b.s1_ap_start, 0);
                    chk("s0_tvalid_route", b.s0_in_TVALID, b.in_s_TVALID);
                    chk("s1_tvalid_iso0", b.s1_in_TVALID, 0);
                    chk("tready_route0", b.in_s_TREADY, b.s0_in_TREADY);
                    chk("idle_in_s0", b.ap_idle, 0);
                    chk("done_in_s0", b.ap_done, 0);
                end
                P_S1: begin
                    chk("s1_start_in_s1", b.s1_ap_start, 1);
                    chk("s0_start_in_s1", b.s0_ap_start, 0);
                    chk("s1_tvalid_route", b.s1_in_TVALID, b.in_s_TVALID);
                    chk("s0_tvalid_iso1", b.s0_in_TVALID, 0);
                    chk("tready_route1", b.in_s_TREADY, b.s1_in_TREADY);
                    chk("idle_in_s1", b.ap_idle, 0);
                    chk("done_in_s1", b.ap_done, 0);
                end
                default: begin
                    chk("tready_off", b.in_s_TREADY, 0);
                    chk("s0_tvalid_off", b.s0_in_TVALID, 0);
                    chk("s1_tvalid_off", b.s1_in_TVALID, 0);
                    chk("s0_start_off", b.s0_ap_start, 0);
                    chk("s1_start_off", b.s1_ap_start, 0);
                    chk("ap_idle", b.ap_idle, (phase == P_IDLE) ? 1 : 0);
                    chk("ap_done", b.ap_done, (phase == P_FIN) ? 1 : 0);
                end
            endcase
            if (b.ap_done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: ap_done with no expected run (t=%0t)", $time);
                end else begin
                    r = sb_q.pop_front();
                    chk("run_beat0", b.beat0_cnt, r.b0);
                    chk("run_beat1", b.beat1_cnt, r.b1);
                    chk("run_stall", b.stall_err, r.st);
                    chk("run_beat_err", b.beat_err, r.be);
                end
            end
        end
    end

    // One cycle of a stage: drive the active stage, put noise on the idle stage, then account.
    task automatic drive_cycle(input int stg, input bit vld, input bit rdy, input bit done);
        b.in_s_TVALID = vld;
        if (stg == 0) begin
            b.s0_in_TREADY = rdy;
            b.s0_ap_done   = done;
            b.s1_in_TREADY = 1'($urandom_range(0, 1));
            b.s1_ap_done   = 1'($urandom_range(0, 1));
        end else begin
            b.s1_in_TREADY = rdy;
            b.s1_ap_done   = done;
            b.s0_in_TREADY = 1'($urandom_range(0, 1));
            b.s0_ap_done   = 1'($urandom_range(0, 1));
        end
        tick();
        if (vld && rdy) begin
            if (stg == 0) m_cnt0++;
            else          m_cnt1++;
        end
        if (rdy && !vld) begin
            streak++;
            if (streak >= LIMIT) m_stall = 1'b1;
        end else begin
            streak = 0;
        end
    endtask

    task automatic run_stage(input int stg, input int n, input int pre);
        int acc;
        bit v, r;
        acc = 0;
        streak = 0;
        for (int i = 0; i < pre; i++) drive_cycle(stg, 1'b0, 1'b1, 1'b0);
        if (pre > 0 && n > 1) begin
            drive_cycle(stg, 1'b1, 1'b1, 1'b0);
            acc++;
        end
        while (acc < n - 1) begin
            v = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 9) < 7);
            drive_cycle(stg, v, r, 1'b0);
            if (v && r) acc++;
        end
        drive_cycle(stg, 1'b1, 1'b1, 1'b1);
        streak = 0;
    endtask

    task automatic noise_all_high();
        b.in_s_TVALID  = 1'b1;
        b.s0_in_TREADY = 1'b1;
        b.s1_in_TREADY = 1'b1;
        b.s0_ap_done   = 1'b1;
        b.s1_ap_done   = 1'b1;
    endtask

    // Starts in IDLE at posedge+1; returns at posedge+1 of the IDLE cycle after FIN (or after a reset).
    task automatic run(input int n0, input int n1, input int pre0, input int pre1,
                       input bit hold_start, input bit do_reset);
        b.ap_start = 1'b1;
        tick();
        phase   = P_S0;
        m_cnt0  = 0;
        m_cnt1  = 0;
        m_stall = 1'b0;
        m_berr  = 1'b0;
        if (!hold_start) b.ap_start = 1'b0;
        run_stage(0, n0, pre0);
`ifdef SEQ_BEAT_CHECK_EN
        if (m_cnt0 != EXP0) m_berr = 1'b1;
`endif
        phase = P_GAP;
        noise_all_high();
        tick();
        phase = P_S1;
        if (do_reset) begin
            for (int i = 0; i < 10; i++) drive_cycle(1, 1'b1, 1'b1, 1'b0);
            phase  = P_OFF;
            ap_rst = 1'b1;
            #1;
            chk("rst_ap_idle", b.ap_idle, 1);
            chk("rst_beat1", b.beat1_cnt, 0);
            chk("rst_beat0", b.beat0_cnt, 0);
            chk("rst_s1_start", b.s1_ap_start, 0);
            chk("rst_tready", b.in_s_TREADY, 0);
            chk("rst_s1_tvalid", b.s1_in_TVALID, 0);
            m_cnt0  = 0;
            m_cnt1  = 0;
            m_stall = 1'b0;
            m_berr  = 1'b0;
            tick();
            ap_rst = 1'b0;
            phase  = P_IDLE;
            return;
        end
        run_stage(1, n1, pre1);
`ifdef SEQ_BEAT_CHECK_EN
        if (m_cnt1 != EXP1) m_berr = 1'b1;
`endif
        sb_q.push_back('{m_cnt0, m_cnt1, m_stall, m_berr});
        phase = P_FIN;
        noise_all_high();
        tick();
        phase = P_IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        ap_rst     = 1'b1;
        b.ap_start = 1'b0;
        noise_all_high();
        tick();
        tick();
        chk("reset_idle", b.ap_idle, 1);
        chk("reset_done", b.ap_done, 0);
        chk("reset_ready", b.ap_ready, 0);
        chk("reset_s0_start", b.s0_ap_start, 0);
        chk("reset_s1_start", b.s1_ap_start, 0);
        chk("reset_tready", b.in_s_TREADY, 0);
        chk("reset_beat0", b.beat0_cnt, 0);
        chk("reset_beat1", b.beat1_cnt, 0);
        chk("reset_stall", b.stall_err, 0);
        chk("reset_beat_err", b.beat_err, 0);
        ap_rst = 1'b0;
        phase  = P_IDLE;
        tick();

        run(EXP0, EXP1, 0, 0, 1'b0, 1'b0);
        tick();
        run(20, 12, 0, LIMIT, 1'b0, 1'b0);
        tick();
        run(12, 10, LIMIT - 1, LIMIT - 1, 1'b0, 1'b0);
        run(15, 30, 0, 0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 3; k++) begin
            run($urandom_range(1, 30), $urandom_range(1, 15), 0, 0, 1'b1, 1'b0);
        end
        b.ap_start = 1'b0;
        tick();
        for (int k = 0; k < 6; k++) begin
            run($urandom_range(1, 40), $urandom_range(1, 20),
                $urandom_range(0, LIMIT), $urandom_range(0, LIMIT), 1'b0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        tick();
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
